// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM that owns the PC
// Ports: clk/rst (async, active-high); imem handshake o_imem_req/o_imem_addr/i_imem_ack/o_ir_load;
//   decoder fields i_ldst/i_snl/i_halt/i_en/i_branch/i_set_flags/i_imm plus i_cond_true;
//   dmem handshake o_dmem_req/o_dmem_we/i_dmem_ack; strobes o_reg_we/o_flags_we;
//   status o_halted/o_state/o_retired.
// Optional feature: define CTRL_PERF_CNT_EN to build the retired-instruction counter.
module cpu_control_sequencer #(
  parameter int PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                o_imem_req,
  output logic [PC_WIDTH-1:0] o_imem_addr,
  input  logic                i_imem_ack,
  output logic                o_ir_load,
  input  logic                i_ldst,
  input  logic                i_snl,
  input  logic                i_halt,
  input  logic                i_en,
  input  logic                i_branch,
  input  logic                i_cond_true,
  input  logic                i_set_flags,
  input  logic [15:0]         i_imm,
  output logic                o_dmem_req,
  output logic                o_dmem_we,
  input  logic                i_dmem_ack,
  output logic                o_reg_we,
  output logic                o_flags_we,
  output logic                o_halted,
  output logic [2:0]          o_state,
  output logic [31:0]         o_retired
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;
  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_pc_br;
  logic                w_to_fetch;
  assign w_pc_inc = r_pc + PC_WIDTH'(1);
  assign w_pc_br  = r_pc + PC_WIDTH'($signed(i_imm));
  // Requests are masked by rst so an in-flight handshake drops the moment reset asserts.
  assign o_imem_req  = (r_state == S_FETCH) & ~rst;
  assign o_ir_load   = o_imem_req & i_imem_ack;
  assign o_dmem_req  = (r_state == S_MEM) & ~rst;
  assign o_dmem_we   = o_dmem_req & i_snl;
  assign o_reg_we    = r_state == S_WB;
  assign o_flags_we  = (r_state == S_EXEC) & i_set_flags & i_en & ~i_ldst & ~i_branch;
  assign o_halted    = r_state == S_HALT;
  assign o_state     = r_state;
  assign o_imem_addr = r_pc;
  // Instruction completes: NOP/branch out of EXEC, acked store out of MEM, or WB.
  assign w_to_fetch = ((r_state == S_EXEC) & (~i_en | i_branch)) |
                      ((r_state == S_MEM) & i_dmem_ack & i_snl) |
                      (r_state == S_WB);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
    end else begin
      case (r_state)
        S_FETCH:  if (i_imem_ack) r_state <= S_DECODE;
        S_DECODE: r_state <= i_halt ? S_HALT : S_EXEC;
        S_EXEC: begin
          if (!i_en) begin
            r_pc    <= w_pc_inc;
            r_state <= S_FETCH;
          end else if (i_branch) begin
            r_pc    <= i_cond_true ? w_pc_br : w_pc_inc;
            r_state <= S_FETCH;
          end else begin
            r_state <= i_ldst ? S_MEM : S_WB;
          end
        end
        S_MEM: begin
          if (i_dmem_ack && i_snl) begin
            r_pc    <= w_pc_inc;
            r_state <= S_FETCH;
          end else if (i_dmem_ack) begin
            r_state <= S_WB;
          end
        end
        S_WB: begin
          r_pc    <= w_pc_inc;
          r_state <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_retired;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_retired <= '0;
    else if (w_to_fetch) r_retired <= r_retired + 32'd1;
  end
  assign o_retired = r_retired;
`else
  logic w_unused;
  assign w_unused  = w_to_fetch;
  assign o_retired = 32'd0;
`endif
endmodule

// File: tb/tb_cpu_control_sequencer.sv
// tb_cpu_control_sequencer: directed self-checking bench for cpu_control_sequencer
module tb_cpu_control_sequencer;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, ir_load, dmem_req, dmem_we, reg_we, flags_we, halted;
  logic [15:0] imem_addr;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        imem_ack, ldst, snl, halt, en, branch, cond_true, set_flags, dmem_ack;
  logic [15:0] imm;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_ret = 0;
  cpu_control_sequencer dut (
    .clk(clk), .rst(rst),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack), .o_ir_load(ir_load),
    .i_ldst(ldst), .i_snl(snl), .i_halt(halt), .i_en(en), .i_branch(branch),
    .i_cond_true(cond_true), .i_set_flags(set_flags), .i_imm(imm),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .i_dmem_ack(dmem_ack),
    .o_reg_we(reg_we), .o_flags_we(flags_we), .o_halted(halted),
    .o_state(state), .o_retired(retired)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] exp_ret(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction
  task automatic br(input logic [15:0] off, input logic c, input logic [15:0] exp_pc);
    branch = 1; en = 1; ldst = 0; snl = 0; cond_true = c; imm = off; set_flags = 1;
    tick;
    tick;
    chk("br_exec_state", state, 3'd2);
    chk("br_flags_we", flags_we, 1'b0);
    chk("br_reg_we", reg_we, 1'b0);
    tick;
    n_ret++;
    chk("br_state", state, 3'd0);
    chk("br_pc", imem_addr, exp_pc);
    chk("br_retired", retired, exp_ret(n_ret));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    rst = 1; imem_ack = 1; ldst = 0; snl = 0; halt = 0; en = 1; branch = 0;
    cond_true = 0; set_flags = 1; imm = 0; dmem_ack = 0;
    #1;
    chk("rst_state", state, 3'd0);
    chk("rst_pc", imem_addr, 16'h0000);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_ir_load", ir_load, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_retired", retired, 32'd0);
    tick;
    rst = 0;
    #1;
    chk("alu_ir_load", ir_load, 1'b1);
    chk("alu_imem_req", imem_req, 1'b1);
    tick;
    chk("alu_decode", state, 3'd1);
    chk("alu_dec_ir_load", ir_load, 1'b0);
    chk("alu_dec_imem_req", imem_req, 1'b0);
    tick;
    chk("alu_exec", state, 3'd2);
    chk("alu_flags_we", flags_we, 1'b1);
    chk("alu_exec_reg_we", reg_we, 1'b0);
    tick;
    chk("alu_wb_reg_we", reg_we, 1'b1);
    chk("alu_wb_flags_we", flags_we, 1'b0);
    chk("alu_wb_pc", imem_addr, 16'h0000);
    tick;
    n_ret++;
    chk("alu_pc", imem_addr, 16'h0001);
    chk("alu_reg_we_off", reg_we, 1'b0);
    chk("alu_retired", retired, exp_ret(n_ret));
    ldst = 1; snl = 0;
    tick;
    tick;
    chk("ld_flags_we", flags_we, 1'b0);
    tick;
    for (int k = 0; k < 3; k++) begin
      chk("ld_wait_state", state, 3'd3);
      chk("ld_wait_req", dmem_req, 1'b1);
      chk("ld_wait_we", dmem_we, 1'b0);
      tick;
    end
    dmem_ack = 1;
    #1;
    chk("ld_ack_req", dmem_req, 1'b1);
    chk("ld_ack_reg_we", reg_we, 1'b0);
    tick;
    dmem_ack = 0;
    chk("ld_wb_state", state, 3'd4);
    chk("ld_wb_req", dmem_req, 1'b0);
    chk("ld_wb_reg_we", reg_we, 1'b1);
    tick;
    n_ret++;
    chk("ld_pc", imem_addr, 16'h0002);
    chk("ld_retired", retired, exp_ret(n_ret));
    snl = 1;
    tick;
    tick;
    tick;
    chk("st_req", dmem_req, 1'b1);
    chk("st_we", dmem_we, 1'b1);
    dmem_ack = 1;
    tick;
    dmem_ack = 0;
    n_ret++;
    chk("st_state", state, 3'd0);
    chk("st_reg_we", reg_we, 1'b0);
    chk("st_pc", imem_addr, 16'h0003);
    chk("st_retired", retired, exp_ret(n_ret));
    br(16'h000D, 1'b1, 16'h0010);
    br(16'hFFFC, 1'b1, 16'h000C);
    br(16'h0004, 1'b1, 16'h0010);
    br(16'h0040, 1'b0, 16'h0011);
    br(16'hFFEE, 1'b1, 16'hFFFF);
    branch = 0; ldst = 0; snl = 0; en = 1; set_flags = 0;
    tick;
    tick;
    chk("wrap_flags_we", flags_we, 1'b0);
    tick;
    chk("wrap_reg_we", reg_we, 1'b1);
    tick;
    n_ret++;
    chk("wrap_pc", imem_addr, 16'h0000);
    chk("wrap_retired", retired, exp_ret(n_ret));
    en = 0; set_flags = 1;
    tick;
    tick;
    chk("nop_flags_we", flags_we, 1'b0);
    chk("nop_reg_we", reg_we, 1'b0);
    tick;
    n_ret++;
    chk("nop_state", state, 3'd0);
    chk("nop_pc", imem_addr, 16'h0001);
    chk("nop_retired", retired, exp_ret(n_ret));
    halt = 1; en = 0;
    tick;
    tick;
    for (int k = 0; k < 5; k++) begin
      chk("halt_state", state, 3'd5);
      chk("halt_halted", halted, 1'b1);
      chk("halt_imem_req", imem_req, 1'b0);
      chk("halt_pc", imem_addr, 16'h0001);
      chk("halt_retired", retired, exp_ret(n_ret));
      tick;
    end
    rst = 1;
    tick;
    rst = 0; halt = 0; en = 1; ldst = 1; snl = 0; dmem_ack = 0;
    #1;
    chk("rst2_state", state, 3'd0);
    chk("rst2_halted", halted, 1'b0);
    tick;
    tick;
    tick;
    chk("mem_state", state, 3'd3);
    chk("mem_req", dmem_req, 1'b1);
    #1;
    rst = 1;
    #1;
    chk("mem_rst_req", dmem_req, 1'b0);
    chk("mem_rst_state", state, 3'd0);
    tick;
    rst = 0;
    #1;
    chk("post_rst_state", state, 3'd0);
    chk("post_rst_pc", imem_addr, 16'h0000);
    chk("post_rst_retired", retired, 32'd0);
    chk("post_rst_imem_req", imem_req, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
